// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between an observed traffic-light controller and its monitor.
interface traffic_light_monitor_if #(
  parameter int CNT_WIDTH = 5
);
  logic                 en;
  logic                 sec_tick;
  logic                 green_light;
  logic                 yellow_light;
  logic                 red_light;
  logic                 clr_fault;

  // phase_done is a one-cycle event with no back-pressure: phase_id/phase_len
  // are valid with it and hold until the next event.
  logic                 phase_done;
  logic [1:0]           phase_id;
  logic [CNT_WIDTH-1:0] phase_len;
  logic                 fault;
  logic [2:0]           fault_code;
  logic [2:0]           dbg_state;

  modport master (
    output en, sec_tick, green_light, yellow_light, red_light, clr_fault,
    input  phase_done, phase_id, phase_len, fault, fault_code, dbg_state
  );

  modport slave (
    input  en, sec_tick, green_light, yellow_light, red_light, clr_fault,
    output phase_done, phase_id, phase_len, fault, fault_code, dbg_state
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Watches three lamp inputs, measures each phase in sec_tick units and flags
// illegal patterns, out-of-order changes and phases that run short or long.
module traffic_light_monitor #(
  parameter int pTIME_GREEN_LIGHT  = 15,
  parameter int pTIME_YELLOW_LIGHT = 3,
  parameter int pTIME_RED_LIGHT    = 18,
  parameter int pCNT_WIDTH         = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_RED    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [2:0] F_ILLEGAL = 3'd1;
  localparam logic [2:0] F_ORDER   = 3'd2;
  localparam logic [2:0] F_SHORT   = 3'd3;
  localparam logic [2:0] F_LONG    = 3'd4;

  localparam logic [pCNT_WIDTH:0]   EXP_GREEN  = (pCNT_WIDTH+1)'(pTIME_GREEN_LIGHT);
  localparam logic [pCNT_WIDTH:0]   EXP_YELLOW = (pCNT_WIDTH+1)'(pTIME_YELLOW_LIGHT);
  localparam logic [pCNT_WIDTH:0]   EXP_RED    = (pCNT_WIDTH+1)'(pTIME_RED_LIGHT);
  localparam logic [pCNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE    = 1;

  state_t                  state;
  logic                    partial;
  logic [pCNT_WIDTH-1:0]   cnt;
  logic                    phase_done_q;
  logic [1:0]              phase_id_q;
  logic [pCNT_WIDTH-1:0]   phase_len_q;
  logic                    fault_q;
  logic [2:0]              fault_code_q;

  logic [2:0]              lamps;
  logic                    lamp_legal;
  state_t                  lamp_state;
  state_t                  next_phase;
  logic [pCNT_WIDTH:0]     exp_len;
  logic [1:0]              ended_id;
  logic [pCNT_WIDTH-1:0]   cnt_inc;
  logic                    fault_det;
  logic [2:0]              fault_cause;
  logic                    change_ok;

  assign lamps      = {mon.red_light, mon.yellow_light, mon.green_light};
  assign lamp_legal = $onehot(lamps);
  assign cnt_inc    = (mon.sec_tick && cnt != CNT_MAX) ? cnt + CNT_ONE : cnt;

  always_comb begin
    lamp_state = S_IDLE;
    case (lamps)
      3'b001:  lamp_state = S_GREEN;
      3'b010:  lamp_state = S_YELLOW;
      3'b100:  lamp_state = S_RED;
      default: lamp_state = S_IDLE;
    endcase

    next_phase = S_IDLE;
    exp_len    = EXP_RED;
    ended_id   = 2'd0;
    case (state)
      S_GREEN:  begin next_phase = S_YELLOW; exp_len = EXP_GREEN;  ended_id = 2'd1; end
      S_YELLOW: begin next_phase = S_RED;    exp_len = EXP_YELLOW; ended_id = 2'd2; end
      S_RED:    begin next_phase = S_GREEN;  exp_len = EXP_RED;    ended_id = 2'd3; end
      default:  ;
    endcase

    // Cause priority falls out of the if-chain order: illegal, order, short, long.
    fault_det   = 1'b0;
    fault_cause = 3'd0;
    change_ok   = 1'b0;
    if (state inside {S_GREEN, S_YELLOW, S_RED}) begin
      if (!lamp_legal) begin
        fault_det   = 1'b1;
        fault_cause = F_ILLEGAL;
      end else if (lamp_state != state) begin
        if (lamp_state != next_phase) begin
          fault_det   = 1'b1;
          fault_cause = F_ORDER;
        end else if (!partial && ({1'b0, cnt} < exp_len)) begin
          fault_det   = 1'b1;
          fault_cause = F_SHORT;
        end else begin
          change_ok = 1'b1;
        end
      end else if (!partial && ({1'b0, cnt_inc} > exp_len)) begin
        fault_det   = 1'b1;
        fault_cause = F_LONG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      partial      <= 1'b0;
      cnt          <= '0;
      phase_done_q <= 1'b0;
      phase_id_q   <= 2'd0;
      phase_len_q  <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
    end else if (mon.clr_fault) begin
      state        <= S_IDLE;
      partial      <= 1'b0;
      cnt          <= '0;
      phase_done_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
    end else begin
      // phase_done stays a single-cycle pulse even if en drops right after it.
      phase_done_q <= 1'b0;
      if (mon.en) begin
        case (state)
          // Non-one-hot patterns in IDLE are treated as "not started yet".
          S_IDLE: begin
            if (lamp_legal) begin
              state   <= lamp_state;
              cnt     <= '0;
              partial <= 1'b1;
            end
          end
          S_GREEN, S_YELLOW, S_RED: begin
            if (fault_det) begin
              state        <= S_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= fault_cause;
            end else if (change_ok) begin
              state   <= lamp_state;
              cnt     <= mon.sec_tick ? CNT_ONE : '0;
              partial <= 1'b0;
              if (!partial) begin
                phase_done_q <= 1'b1;
                phase_id_q   <= ended_id;
                phase_len_q  <= cnt;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mon.phase_done = phase_done_q;
  assign mon.phase_id   = phase_id_q;
  assign mon.phase_len  = phase_len_q;
  assign mon.fault      = fault_q;
  assign mon.fault_code = fault_code_q;
  assign mon.dbg_state  = state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios followed by random lamp
// sequences, all checked against a tick-counting reference model.
module tb_traffic_light_monitor;

  localparam int CW   = 5;
  localparam int W    = 2 + CW;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [2:0] L_G = 3'b001;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_R = 3'b100;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  traffic_light_monitor_if #(.CNT_WIDTH(CW)) bus ();

  traffic_light_monitor #(
    .pTIME_GREEN_LIGHT (15),
    .pTIME_YELLOW_LIGHT(3),
    .pTIME_RED_LIGHT   (18),
    .pCNT_WIDTH        (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] seen_q[$];

  // reference model: phase 0 = none, 1 green, 2 yellow, 3 red
  int m_phase, m_cnt, m_code, m_id, m_len;
  bit m_partial, m_fault, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_of(input int p);
    case (p)
      1:       return 15;
      2:       return 3;
      default: return 18;
    endcase
  endfunction

  function automatic int lamp_phase(input logic [2:0] l);
    if ($countones(l) != 1) return 0;
    if (l[0]) return 1;
    if (l[1]) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_code = 0; m_id = 0; m_len = 0;
    m_partial = 0; m_fault = 0; m_done = 0;
    exp_q.delete();
  endtask

  task automatic model_fault(input int c);
    m_fault = 1;
    m_code  = c;
  endtask

  task automatic model_step(input bit en, input bit tick, input logic [2:0] l, input bit clr);
    int lp;
    logic [W-1:0] ev;
    m_done = 0;
    if (clr) begin
      m_phase = 0; m_cnt = 0; m_partial = 0; m_fault = 0; m_code = 0;
      return;
    end
    if (!en || m_fault) return;
    lp = lamp_phase(l);
    if (m_phase == 0) begin
      if (lp != 0) begin
        m_phase = lp; m_cnt = 0; m_partial = 1;
      end
      return;
    end
    if (lp == 0) model_fault(1);
    else if (lp != m_phase) begin
      if (lp != m_phase % 3 + 1) model_fault(2);
      else if (!m_partial && m_cnt < exp_of(m_phase)) model_fault(3);
      else begin
        if (!m_partial) begin
          m_done = 1; m_id = m_phase; m_len = m_cnt;
          ev = {m_id[1:0], m_len[CW-1:0]};
          exp_q.push_back(ev);
        end
        m_phase = lp; m_cnt = tick ? 1 : 0; m_partial = 0;
      end
    end else begin
      if (tick && m_cnt < MAXC) m_cnt++;
      if (!m_partial && m_cnt > exp_of(m_phase)) model_fault(4);
    end
  endtask

  // scoreboard: every sampled cycle is compared against the model
  task automatic compare_outputs();
    logic [W-1:0] got_ev;
    check("phase_done", bus.phase_done, m_done);
    check("fault", bus.fault, m_fault);
    check("fault_code", bus.fault_code, m_code);
    check("phase_id", bus.phase_id, m_id);
    check("phase_len", bus.phase_len, m_len);
    if (bus.phase_done) begin
      got_ev = {bus.phase_id, bus.phase_len};
      seen_q.push_back(got_ev);
      check("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) check("sb_event", got_ev, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic step(input bit en, input bit tick, input logic [2:0] l, input bit clr);
    bus.en        = en;
    bus.sec_tick  = tick;
    {bus.red_light, bus.yellow_light, bus.green_light} = l;
    bus.clr_fault = clr;
    @(posedge clk);
    model_step(en, tick, l, clr);
    #1;
    compare_outputs();
  endtask

  task automatic hold(input logic [2:0] l, input int n);
    step(1'b1, 1'b0, l, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, l, 1'b0);
      step(1'b1, 1'b0, l, 1'b0);
    end
  endtask

  initial begin
    logic [2:0] l;
    int n, nxt, got_ticks, guard;
    bit r_en, r_tick, r_clr;

    rst_n = 1'b0;
    bus.en = 1'b0; bus.sec_tick = 1'b0; bus.clr_fault = 1'b0;
    bus.green_light = 1'b0; bus.yellow_light = 1'b0; bus.red_light = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase_done", bus.phase_done, 0);
    check("rst_phase_id", bus.phase_id, 0);
    check("rst_phase_len", bus.phase_len, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_fault_code", bus.fault_code, 0);
    @(negedge clk) rst_n = 1'b1;

    // nominal cycle with partial first green
    seen_q.delete();
    hold(L_G, 5); hold(L_Y, 3); hold(L_R, 18); hold(L_G, 15); hold(L_Y, 2);
    check("s1_events", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("s1_ev0", seen_q[0], {2'd2, 5'd3});
      check("s1_ev1", seen_q[1], {2'd3, 5'd18});
      check("s1_ev2", seen_q[2], {2'd1, 5'd15});
    end
    check("s1_fault", bus.fault, 0);

    // yellow cut short after 2 ticks
    step(1'b1, 1'b0, L_R, 1'b0);
    check("s2_fault", bus.fault, 1);
    check("s2_code", bus.fault_code, 3);
    check("s2_no_done", bus.phase_done, 0);

    // green overstays: fault right after the 16th tick
    step(1'b1, 1'b0, L_R, 1'b1);
    hold(L_R, 2); hold(L_G, 15);
    check("s3_pre_fault", bus.fault, 0);
    step(1'b1, 1'b1, L_G, 1'b0);
    check("s3_fault", bus.fault, 1);
    check("s3_code", bus.fault_code, 4);

    // order and illegal-pattern faults
    step(1'b1, 1'b0, L_G, 1'b1);
    hold(L_R, 1); hold(L_G, 2);
    step(1'b1, 1'b0, L_R, 1'b0);
    check("s4_order", bus.fault_code, 2);
    step(1'b1, 1'b0, L_G, 1'b1);
    hold(L_G, 1);
    step(1'b1, 1'b0, 3'b011, 1'b0);
    check("s4_illegal_011", bus.fault_code, 1);
    step(1'b1, 1'b0, L_G, 1'b1);
    hold(L_G, 1);
    step(1'b1, 1'b0, 3'b000, 1'b0);
    check("s4_illegal_000", bus.fault_code, 1);

    // clear wins over a simultaneous illegal pattern
    step(1'b1, 1'b0, 3'b011, 1'b1);
    check("s5_fault", bus.fault, 0);
    check("s5_code", bus.fault_code, 0);
    step(1'b1, 1'b0, 3'b011, 1'b0);
    check("s5_idle", bus.fault, 0);

    // disable mid-red, then a lamp change made while disabled
    hold(L_Y, 1); hold(L_R, 5);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, L_R, 1'b0);
      step(1'b0, 1'b0, L_R, 1'b0);
    end
    hold(L_R, 13);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, L_G, 1'b0);
    step(1'b1, 1'b0, L_G, 1'b0);
    check("s6_done", bus.phase_done, 1);
    check("s6_id", bus.phase_id, 3);
    check("s6_len", bus.phase_len, 18);

    // asynchronous reset mid-red
    hold(L_G, 15); hold(L_Y, 3); hold(L_R, 4);
    #2 rst_n = 1'b0;
    #1;
    check("s7_phase_done", bus.phase_done, 0);
    check("s7_phase_id", bus.phase_id, 0);
    check("s7_phase_len", bus.phase_len, 0);
    check("s7_fault", bus.fault, 0);
    check("s7_fault_code", bus.fault_code, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    hold(L_R, 3); hold(L_G, 15); hold(L_Y, 3);

    // random segments: mostly in-order phases near nominal length
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        l = 3'($urandom_range(0, 7));
        n = $urandom_range(0, 4);
      end else begin
        nxt = (m_phase == 0) ? $urandom_range(1, 3) : m_phase % 3 + 1;
        l = 3'b001 << (nxt - 1);
        case ($urandom_range(0, 5))
          0:       n = exp_of(nxt) - 1;
          5:       n = exp_of(nxt) + 1;
          default: n = exp_of(nxt);
        endcase
      end
      got_ticks = 0;
      guard = 0;
      do begin
        r_en   = ($urandom_range(0, 15) != 0);
        r_tick = $urandom_range(0, 1);
        r_clr  = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
        step(r_en, r_tick, l, r_clr);
        if (r_en && r_tick) got_ticks++;
        guard++;
      end while (got_ticks < n && guard < 300);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameters (name, default, meaning):
- pTIME_GREEN_LIGHT, 15, expected green duration in sec_tick pulses.
- pTIME_YELLOW_LIGHT, 3, expected yellow duration in ticks.
- pTIME_RED_LIGHT, 18, expected red duration in ticks.
- pCNT_WIDTH, 5, duration counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, all logic on rising edge.
- rst_n, in, 1, reset, asynchronous assert, active-low.
- en, in, 1, monitor enable.
- sec_tick, in, 1, one-cycle pulse per elapsed second.
- green_light, in, 1, lamp under observation.
- yellow_light, in, 1, lamp under observation.
- red_light, in, 1, lamp under observation.
- clr_fault, in, 1, clears the sticky fault.
- phase_done, out, 1, one-cycle pulse on every legal phase change.
- phase_id, out, 2, ended phase: 1 green, 2 yellow, 3 red.
- phase_len, out, pCNT_WIDTH, measured tick count of the ended phase.
- fault, out, 1, sticky fault flag.
- fault_code, out, 3, first fault cause.

Function
REQ-003 Lamp vector L={red,yellow,green}; legal only if exactly one bit is set.
REQ-004 State machine states: IDLE, GREEN, YELLOW, RED, FAULT.
REQ-005 IDLE + legal L: enter the matching phase state.
- Counter is cleared to 0.
- The first phase after IDLE is partial: its duration is never checked and it produces no phase_done.
REQ-006 Legal order is GREEN->YELLOW->RED->GREEN only.
REQ-007 Within a phase, each sec_tick increments the counter.
- The counter saturates at 2^pCNT_WIDTH-1.
- A sec_tick on the same cycle as a lamp change counts toward the new phase: the new counter loads 1, otherwise 0.
REQ-008 On a legal change, in the next cycle:
- phase_done=1;
- phase_id = ended phase;
- phase_len = final count of the ended phase.
- phase_id and phase_len hold until the next phase_done.
REQ-009 Duration is checked only for phases entered from a previous checked or partial phase (not IDLE):
- change with count < expected -> fault code 3 (SHORT);
- count reaching expected+1 while still in phase -> code 4 (LONG), flagged immediately, no wait for change.
REQ-010 Other fault causes:
- illegal L -> code 1 (ILLEGAL);
- legal L out of order -> code 2 (ORDER).
REQ-011 Priority when causes coincide: ILLEGAL > ORDER > SHORT > LONG.
REQ-012 Any fault:
- fault=1 and fault_code latched on the clock edge after the offending sample;
- state goes to FAULT;
- no phase_done for the offending transition.
REQ-013 In FAULT:
- fault and fault_code are held;
- no further checking or phase_done.
REQ-014 clr_fault=1 from any state:
- fault=0, fault_code=0, state to IDLE, counter to 0, next cycle.
- clr_fault has priority over any simultaneous fault.
REQ-015 en=0: state, counter and outputs are frozen; lamps and sec_tick are ignored; clr_fault still acts.
REQ-016 On en returning to 1, comparisons resume against the frozen state; a lamp change made while disabled is evaluated then.
REQ-017 phase_done is never asserted in the same cycle as a fault assertion.

Reset
REQ-018 rst_n=0 asynchronously forces:
- state IDLE, counter 0;
- phase_done=0, phase_id=0, phase_len=0, fault=0, fault_code=0.
REQ-019 Reset mid-phase discards the partial measurement; after release the first observed phase is partial per REQ-005.

Verification
REQ-020 The bench shall cover these directed scenarios (stimulus -> required response):
- Reset, then green for 5 ticks (partial), yellow 3, red 18, green 15 -> phase_done with (2,3), (3,18), (1,15); fault=0.
- In YELLOW after 2 ticks, L=red -> fault=1, code=3, no phase_done.
- GREEN held for 16 ticks -> fault=1, code=4 on the cycle after the 16th tick.
- In GREEN, L=red -> code 2; separately, L=3'b011 -> code 1; L=3'b000 -> code 1.
- Fault active, then clr_fault with a simultaneous illegal L -> fault=0, code=0, state IDLE.
- en=0 for 10 ticks mid-red -> counter frozen; phase_len on the red->green change is unaffected by the disabled ticks.
- rst_n pulsed low mid-red -> all outputs 0 immediately, without waiting for clk.
